// File: rtl/click_decoder_pkg.sv
// Shared types and width helpers for the click decoder.
//   click_state_t : sequence FSM states (IDLE, COUNT)
//   cnt_w()       : click counter width for a given MAX_CLICKS
//   tmr_w()       : window timer width for a given CLICK_WINDOW
package click_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } click_state_t;

  // Counter must hold 0..max_clicks.
  function automatic int unsigned cnt_w(input int unsigned max_clicks);
    return $clog2(max_clicks + 1);
  endfunction

  // Timer only ever holds 0..window-1.
  function automatic int unsigned tmr_w(input int unsigned window);
    return $clog2(window);
  endfunction

endpackage

// File: rtl/click_decoder_if.sv
// Valid/ready click event channel.
//   evt_valid : an event is pending (source -> sink)
//   evt_ready : sink accepts the pending event (sink -> source)
//   evt_count : click count of the pending event (source -> sink)
interface click_decoder_if
  import click_pkg::*;
#(
  parameter int unsigned CNT_W = cnt_w(3)
);

  logic             evt_valid;
  logic             evt_ready;
  logic [CNT_W-1:0] evt_count;

  modport master (
    output evt_valid,
    output evt_count,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_count,
    output evt_ready
  );

endinterface

// File: rtl/click_decoder.sv
// Groups debounced press pulses into single/double/.../MAX_CLICKS click
// events and hands each completed sequence to a one-entry valid/ready slot.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   press_pls : one-cycle press pulse from the debouncer
//   evt       : event channel (master side): evt_valid/evt_count out, evt_ready in
//   busy      : a click sequence is in progress
//   drop_pls  : completed sequence discarded because the slot was full
module click_decoder
  import click_pkg::*;
#(
  parameter int unsigned CLICK_WINDOW = 25_000_000,
  parameter int unsigned MAX_CLICKS   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             press_pls,
  click_decoder_if.master  evt,
  output logic             busy,
  output logic             drop_pls
);

  localparam int unsigned CNT_W = cnt_w(MAX_CLICKS);
  localparam int unsigned TMR_W = tmr_w(CLICK_WINDOW);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CLICKS);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLICK_WINDOW - 1);

  if (CLICK_WINDOW < 2) begin : g_bad_window
    $error("click_decoder: CLICK_WINDOW must be at least 2");
  end
  if (MAX_CLICKS < 2) begin : g_bad_max
    $error("click_decoder: MAX_CLICKS must be at least 2");
  end

  click_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_d, drop_d;

  logic             done_c;
  logic [CNT_W-1:0] done_cnt_c;
  logic [CNT_W-1:0] cnt_inc_c;

  assign cnt_inc_c = cnt_q + CNT_W'(1);

  // Next-state, counter/timer and output slot logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmr_d      = tmr_q;
    done_c     = 1'b0;
    done_cnt_c = cnt_q;
    drop_d     = 1'b0;
    // An accepted event frees the slot; the count is left as-is.
    valid_d    = valid_q & ~evt.evt_ready;
    count_d    = count_q;

    unique case (state_q)
      IDLE: begin
        if (press_pls) begin
          state_d = COUNT;
          cnt_d   = CNT_W'(1);
          tmr_d   = '0;
        end
      end
      COUNT: begin
        // A pulse in the timeout cycle still extends the sequence.
        if (press_pls) begin
          cnt_d = cnt_inc_c;
          tmr_d = '0;
          if (cnt_inc_c == CNT_MAX) begin
            done_c     = 1'b1;
            done_cnt_c = cnt_inc_c;
          end
        end else if (tmr_q == TMR_LAST) begin
          done_c     = 1'b1;
          done_cnt_c = cnt_q;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (done_c) begin
      state_d = IDLE;
      cnt_d   = '0;
      tmr_d   = '0;
      // Slot is free if empty or being drained this cycle.
      if (!valid_q || evt.evt_ready) begin
        valid_d = 1'b1;
        count_d = done_cnt_c;
      end else begin
        drop_d = 1'b1;
      end
    end

    busy_d = (state_d == COUNT);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tmr_q    <= '0;
      valid_q  <= 1'b0;
      count_q  <= '0;
      busy     <= 1'b0;
      drop_pls <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
      busy     <= busy_d;
      drop_pls <= drop_d;
    end
  end

  assign evt.evt_valid = valid_q;
  assign evt.evt_count = count_q;

endmodule

// File: doc/click_decoder.md
# click_decoder

Groups single-cycle press pulses from the button debouncer into click events: single, double, up to `MAX_CLICKS`. A click belongs to the current sequence if it arrives within `CLICK_WINDOW` cycles of the previous one. Each completed sequence is handed to downstream control logic as a one-entry valid/ready event carrying the click count. The block sits directly after the debouncer, and its `press_pls` input is the debouncer's one-cycle press pulse.

## Interface

- `CLICK_WINDOW`, default 25_000_000: maximum gap in cycles between consecutive clicks of one sequence. Must be at least 2.
- `MAX_CLICKS`, default 3: sequence length at which the event is emitted immediately. Must be at least 2.
- `clk`, input, 1: the single clock; all logic is on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `press_pls`, input, 1: one-cycle press pulse from the debouncer.
- `evt_valid`, output, 1: a click event is pending.
- `evt_ready`, input, 1: the consumer accepts the event.
- `evt_count`, output, `CNT_W`: click count of the pending event, in the range 1 to `MAX_CLICKS`.
- `busy`, output, 1: a sequence is in progress (state is COUNT).
- `drop_pls`, output, 1: one-cycle pulse when a completed sequence is discarded because the output slot is full.

## Operation

- Widths:
  - `CNT_W = $clog2(MAX_CLICKS+1)`.
  - `TMR_W = $clog2(CLICK_WINDOW)`.
- State IDLE:
  - `press_pls` sets `cnt=1`, `tmr=0`, and moves to COUNT.
- State COUNT, `press_pls=1`:
  - `cnt` increments and `tmr` clears to 0.
  - If the new `cnt` equals `MAX_CLICKS`, the sequence completes and the state returns to IDLE.
- State COUNT, `press_pls=0`:
  - If `tmr == CLICK_WINDOW-1`, the sequence completes with the current `cnt` and the state returns to IDLE.
  - Otherwise `tmr` increments.
- Simultaneous pulse and timeout: the pulse wins. The click is counted and the window restarts.
- Completion, slot free: the slot is free when `evt_valid=0`, or when `evt_valid & evt_ready` in the same cycle. The event loads into the slot (`evt_valid=1`, `evt_count=cnt`).
- Completion, slot full: the event is discarded, `drop_pls=1` for one cycle, and the slot contents are unchanged.
- Handshake:
  - A transfer occurs on any cycle with `evt_valid & evt_ready`.
  - `evt_valid` stays high until accepted.
  - `evt_count` is stable while `evt_valid & ~evt_ready`.
  - `evt_ready` may be held high permanently.
  - `evt_valid` never depends combinationally on `evt_ready`.
- A pulse arriving in IDLE in the cycle after a completion starts a new sequence normally.
- Counter arithmetic never wraps: `cnt` cannot exceed `MAX_CLICKS` and `tmr` cannot exceed `CLICK_WINDOW-1`.

## Timing

- Reset values: `evt_valid=0`, `evt_count=0`, `busy=0`, `drop_pls=0`, state IDLE, `cnt=0`, `tmr=0`.
- Reset mid-sequence or with an event pending: everything clears, and the pending event is lost without a `drop_pls`.
- All outputs are registered. `press_pls` is only sampled when `rst=0`.
- `busy` rises in cycle c+1 after a pulse in cycle c from IDLE.
- Window timeout: for the last pulse in cycle c, `tmr` reaches `CLICK_WINDOW-1` in cycle c+`CLICK_WINDOW`. `evt_valid` rises and `busy` falls in cycle c+`CLICK_WINDOW`+1.
- Early completion: for the `MAX_CLICKS`-th pulse in cycle c, `evt_valid` rises and `busy` falls in cycle c+1.
- `drop_pls` is asserted in the same cycle that `evt_valid` would have risen.
- Accept: with `evt_ready=1` in cycle a, `evt_valid` is 0 in cycle a+1 unless a new completion loads in cycle a.

## Structure

- Package `click_pkg` holds:
  - the state typedef `click_state_t` with values IDLE and COUNT;
  - `CNT_W`/`TMR_W` width helper functions.
- Single module with no sub-modules. The timer, counter, FSM and output slot are inline.
- Elaboration-time assertions check `CLICK_WINDOW >= 2` and `MAX_CLICKS >= 2`.

## Test plan

Simulation uses `CLICK_WINDOW=16` and `MAX_CLICKS=3`, with `evt_ready=1` unless stated otherwise.

- Single click: pulse at cycle 10 gives `evt_valid` for one cycle in cycle 27 with `evt_count=1`; `busy` is high in cycles 11–26.
- Double click: pulses at 10 and 25 give one event with `evt_count=2` in cycle 42; pulses at 10 and 27 give two events, each with `evt_count=1`, in cycles 27 and 44.
- Early completion: pulses at 10, 12 and 14 give `evt_count=3` in cycle 15, and `busy=0` in cycle 15.
- Back-pressure: with `evt_ready=0`, a single click gives `evt_valid` held with `evt_count=1`. A second completed sequence gives `drop_pls=1` in its completion cycle and the slot still holds 1. Raising `evt_ready` gives exactly one transfer.
- Collision: a pulse in the timeout cycle (cycle 26 after a pulse at 10) gives no event at 27 and a single `evt_count=2` event in cycle 43.
- Reset mid-sequence: pulses at 10 and 12, then `rst` at cycle 14, give no event ever; all outputs are 0 in cycle 15, and a new pulse at 20 gives `evt_count=1` in cycle 37.
